// File: rtl/fifo_pkg.sv
// Shared definitions for the single- and dual-clock FIFO family: read modes,
// depth helper and parameter sanity checks.
package fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    localparam int FIFO_MIN_ASIZE     = 1;
    localparam int FIFO_MIN_AEMPTY_TH = 0;

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    // Almost-empty must sit strictly below almost-full, and both inside the usable range.
    function automatic bit fifo_thresholds_ok(input int aemptyTh, input int afullTh, input int depth);
        return (aemptyTh >= FIFO_MIN_AEMPTY_TH) && (aemptyTh < afullTh) && (afullTh <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo_flags: one write port, one registered
// read port with enable, no reset so it maps onto block RAM.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic             re_i,
    input  logic [ASIZE-1:0] raddr_i,
    output logic [DSIZE-1:0] rdata_o
);

    localparam int DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [DSIZE-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic             winc_i,
    input  logic             rinc_i,
    output logic [DSIZE-1:0] rdata_o,
    output logic             wfull_o,
    output logic             rempty_o,
    output logic             walmost_full_o,
    output logic             ralmost_empty_o,
    output logic [ASIZE:0]   count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int             DEPTH      = fifo_depth(ASIZE);
    localparam fifo_mode_e     MODE       = (FWFT == 1) ? FIFO_FWFT : FIFO_STD;
    localparam logic [ASIZE:0] PTR_ONE    = (ASIZE+1)'(1);
    localparam logic [ASIZE:0] CNT_TWO    = (ASIZE+1)'(2);
    localparam logic [ASIZE:0] DEPTH_CNT  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_CNT  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_CNT = (ASIZE+1)'(AEMPTY_TH);

    if (ASIZE < FIFO_MIN_ASIZE) begin : gAsizeCheck
        $error("sync_fifo_flags: ASIZE must be at least 1");
    end
    if (!fifo_thresholds_ok(AEMPTY_TH, AFULL_TH, DEPTH)) begin : gThresholdCheck
        $error("sync_fifo_flags: need 0 <= AEMPTY_TH < AFULL_TH <= DEPTH");
    end
    if ((FWFT != 0) && (FWFT != 1)) begin : gModeCheck
        $error("sync_fifo_flags: FWFT must be 0 or 1");
    end

    logic [ASIZE:0]   wrPtr_q, wrPtr_d;
    logic [ASIZE:0]   rdPtr_q, rdPtr_d;
    logic [ASIZE:0]   rdPtrNext;
    logic [ASIZE:0]   count;
    logic             wfull, rempty;
    logic             we, re;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             ramRe;
    logic [ASIZE-1:0] ramRaddr;
    logic [DSIZE-1:0] ramRdata;
    logic [DSIZE-1:0] bypass_q, bypass_d;
    logic             useBypass_q, useBypass_d;

    // Occupancy falls out of the extra wrap bit on each pointer.
    assign count     = wrPtr_q - rdPtr_q;
    assign wfull     = (count == DEPTH_CNT);
    assign rempty    = (count == '0);
    assign we        = winc_i & ~wfull & ~rst_i;
    assign re        = rinc_i & ~rempty & ~rst_i;
    assign rdPtrNext = rdPtr_q + PTR_ONE;

    always_comb begin
        wrPtr_d     = we ? (wrPtr_q + PTR_ONE) : wrPtr_q;
        rdPtr_d     = re ? rdPtrNext : rdPtr_q;
        overflow_d  = overflow_q | (winc_i & wfull);
        underflow_d = underflow_q | (rinc_i & rempty);
    end

    // Output stage: the bypass register covers reset (rdata reads 0) and, in FWFT,
    // words that must appear before the RAM could return them.
    always_comb begin
        ramRe       = 1'b0;
        ramRaddr    = rdPtr_q[ASIZE-1:0];
        bypass_d    = bypass_q;
        useBypass_d = useBypass_q;
        if (MODE == FIFO_STD) begin
            if (re) begin
                ramRe       = 1'b1;
                useBypass_d = 1'b0;
            end
        end else begin
            if (rempty && we) begin
                bypass_d    = wdata_i;
                useBypass_d = 1'b1;
            end else if (re) begin
                if (count >= CNT_TWO) begin
                    ramRe       = 1'b1;
                    ramRaddr    = rdPtrNext[ASIZE-1:0];
                    useBypass_d = 1'b0;
                end else if (we) begin
                    bypass_d    = wdata_i;
                    useBypass_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            bypass_q    <= '0;
            useBypass_q <= 1'b1;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            bypass_q    <= bypass_d;
            useBypass_q <= useBypass_d;
        end
    end

    sync_fifo_ram #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) uRam (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (wrPtr_q[ASIZE-1:0]),
        .wdata_i (wdata_i),
        .re_i    (ramRe),
        .raddr_i (ramRaddr),
        .rdata_o (ramRdata)
    );

    assign rdata_o         = useBypass_q ? bypass_q : ramRdata;
    assign wfull_o         = wfull;
    assign rempty_o        = rempty;
    assign walmost_full_o  = (count >= AFULL_CNT);
    assign ralmost_empty_o = (count <= AEMPTY_CNT);
    assign count_o         = count;
    assign overflow_o      = overflow_q;
    assign underflow_o     = underflow_q;

endmodule
